pc_sequencer: RTL and testbench
===============================

PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter D, default 12, program-counter width in bits.
REQ-002 Parameter SD, default 4, return-stack depth in entries (SD >= 1).
REQ-003 Parameter DONE_ADDR, default 711, first PC value at which the program counts as finished.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  asynchronous, active-low reset.
REQ-006 Port stall  input  1  hold PC and stack for this cycle.
REQ-007 Port reljump_en  input  1  relative jump request.
REQ-008 Port offset  input  D  two's-complement relative jump displacement.
REQ-009 Port absjump_en  input  1  absolute jump request.
REQ-010 Port target  input  D  absolute jump and call destination.
REQ-011 Port call_en  input  1  subroutine call request.
REQ-012 Port ret_en  input  1  subroutine return request.
REQ-013 Port halt_req  input  1  explicit halt request.
REQ-014 Port prog_ctr  output  D  current program counter, registered.
REQ-015 Port depth  output  clog2(SD+1)  number of valid return-stack entries.
REQ-016 Port done  output  1  sticky program-finished flag, registered.
REQ-017 Port stack_ovf  output  1  sticky flag: a call was attempted with the stack full.
REQ-018 Port stack_unf  output  1  sticky flag: a return was attempted with the stack empty.

Function
REQ-019 Each cycle the sequencer applies exactly one action, chosen in this priority order: done, stall, ret, call, absjump, reljump, increment.
REQ-020 Done: while done=1, prog_ctr, the stack and depth hold; all requests are ignored.
REQ-021 Stall (done=0): prog_ctr, the stack and depth hold; all lower-priority requests are dropped, not queued.
REQ-022 Ret with depth>0: prog_ctr <= top-of-stack entry; depth decrements by 1.
REQ-023 Ret with depth=0: stack_unf <= 1; prog_ctr <= prog_ctr+1; depth stays 0.
REQ-024 Call with depth<SD: push (prog_ctr+1) mod 2^D; depth increments by 1; prog_ctr <= target.
REQ-025 Call with depth=SD: stack_ovf <= 1; no push and no jump; prog_ctr <= prog_ctr+1.
REQ-026 Call and ret asserted together: ret is executed; call is ignored and sets no flag.
REQ-027 Absjump: prog_ctr <= target.
REQ-028 Reljump: prog_ctr <= (prog_ctr + offset) mod 2^D, with offset treated as signed.
REQ-029 Increment: prog_ctr <= (prog_ctr+1) mod 2^D; 2^D-1 wraps to 0.
REQ-030 done is set on the edge after a cycle in which (done=0 and (halt_req=1 or prog_ctr >= DONE_ADDR)); that cycle's PC action still executes.
REQ-031 done, stack_ovf and stack_unf are sticky; only reset clears them.
REQ-032 The stack is LIFO; entries at indices >= depth are don't-care and are never output.
REQ-033 All outputs come directly from registers; there is no combinational input-to-output path.

Reset
REQ-034 While reset=0, asynchronously: prog_ctr=0, depth=0, done=0, stack_ovf=0, stack_unf=0.
REQ-035 Stack entry contents need no reset.
REQ-036 Reset asserted mid-call or mid-return takes effect immediately; the first rising edge after release performs a normal action from PC 0.

Verification (D=12, SD=4, DONE_ADDR=711)
REQ-037 Release reset with no requests for 5 cycles -> prog_ctr 0,1,2,3,4,5; depth=0; all flags 0.
REQ-038 At PC=10: call target=100; at PC=100: call target=200; two increments, then ret; then ret -> PC sequence 10,100,200,201,202,101,11; depth sequence 0,1,2,2,2,1,0.
REQ-039 Five calls back to back from PC=0, each with target=50 -> depth saturates at 4; stack_ovf rises on the 5th call; PC=51 after the 5th call.
REQ-040 Ret at depth=0 with PC=7 -> PC=8, stack_unf=1; flag stays 1 after 20 further cycles.
REQ-041 Reljump at PC=5 with offset=0xFFD (-3) -> PC=2; reljump at PC=4090 with offset=10 -> PC=4.
REQ-042 Absjump target=709 with free-run -> PC reaches 711, done=1 on the next edge, PC then holds at 712; stall, call or halt_req applied afterwards leave the PC unchanged.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program counter sequencer with a bounded return stack, relative/absolute jumps,
// stall, and sticky done / stack-overflow / stack-underflow flags.
module pc_sequencer #(
    parameter int D         = 12,
    parameter int SD        = 4,
    parameter int DONE_ADDR = 711
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     stall,
    input  logic                     reljump_en,
    input  logic [D-1:0]             offset,
    input  logic                     absjump_en,
    input  logic [D-1:0]             target,
    input  logic                     call_en,
    input  logic                     ret_en,
    input  logic                     halt_req,
    output logic [D-1:0]             prog_ctr,
    output logic [$clog2(SD+1)-1:0]  depth,
    output logic                     done,
    output logic                     stack_ovf,
    output logic                     stack_unf
);

    localparam int DW = $clog2(SD + 1);
    localparam int IW = (SD > 1) ? $clog2(SD) : 1;
    // A finish address beyond the PC range can never be reached by the PC.
    localparam bit             DONE_REACHABLE = (DONE_ADDR < (1 << D));
    localparam logic [D-1:0]   DONE_PC        = D'(DONE_ADDR);

    typedef enum logic [2:0] {
        ACT_HOLD,
        ACT_RET,
        ACT_RET_UNF,
        ACT_CALL,
        ACT_CALL_OVF,
        ACT_ABS,
        ACT_REL,
        ACT_INC
    } action_e;

    action_e        action;
    logic [D-1:0]   pc_q, pc_d, pcInc;
    logic [DW-1:0]  depth_q, depth_d;
    logic           done_q, done_d;
    logic           ovf_q, ovf_d;
    logic           unf_q, unf_d;
    logic [D-1:0]   stack_q [SD];
    logic           stackFull, stackEmpty, atDone;
    logic [IW-1:0]  pushIdx, popIdx;

    assign pcInc      = pc_q + D'(1);
    assign stackFull  = (depth_q == DW'(SD));
    assign stackEmpty = (depth_q == '0);
    assign pushIdx    = IW'(depth_q);
    assign popIdx     = IW'(depth_q - DW'(1));
    assign atDone     = DONE_REACHABLE && (pc_q >= DONE_PC);

    always_comb begin
        action = ACT_INC;
        if (done_q || stall) begin
            action = ACT_HOLD;
        end else if (ret_en) begin
            action = stackEmpty ? ACT_RET_UNF : ACT_RET;
        end else if (call_en) begin
            action = stackFull ? ACT_CALL_OVF : ACT_CALL;
        end else if (absjump_en) begin
            action = ACT_ABS;
        end else if (reljump_en) begin
            action = ACT_REL;
        end
    end

    always_comb begin
        pc_d    = pc_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        // The finishing cycle still performs its own PC action; done only blocks later ones.
        done_d  = done_q || halt_req || atDone;
        case (action)
            ACT_HOLD: begin
                pc_d = pc_q;
            end
            ACT_RET: begin
                pc_d    = stack_q[popIdx];
                depth_d = depth_q - DW'(1);
            end
            ACT_RET_UNF: begin
                pc_d  = pcInc;
                unf_d = 1'b1;
            end
            ACT_CALL: begin
                pc_d    = target;
                depth_d = depth_q + DW'(1);
            end
            ACT_CALL_OVF: begin
                pc_d  = pcInc;
                ovf_d = 1'b1;
            end
            ACT_ABS: begin
                pc_d = target;
            end
            ACT_REL: begin
                pc_d = pc_q + offset;
            end
            ACT_INC: begin
                pc_d = pcInc;
            end
            default: begin
                pc_d = pc_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= '0;
            depth_q <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Stack contents are never observed above depth, so they carry no reset.
    always_ff @(posedge clk) begin
        if (reset && action == ACT_CALL) begin
            stack_q[pushIdx] <= pcInc;
        end
    end

    assign prog_ctr  = pc_q;
    assign depth     = depth_q;
    assign done      = done_q;
    assign stack_ovf = ovf_q;
    assign stack_unf = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized traffic, all checked
// against a queue-based behavioural model of the sequencer.
module tb_pc_sequencer;

    localparam int D         = 12;
    localparam int SD        = 4;
    localparam int DONE_ADDR = 711;
    localparam int DW        = $clog2(SD + 1);
    localparam int MOD       = 1 << D;

    logic          clk;
    logic          reset;
    logic          stall, reljump_en, absjump_en, call_en, ret_en, halt_req;
    logic [D-1:0]  offset, target;
    logic [D-1:0]  prog_ctr;
    logic [DW-1:0] depth;
    logic          done, stack_ovf, stack_unf;

    int mPc;
    int mStack[$];
    bit mDone, mOvf, mUnf;
    int errors;
    int checks;

    pc_sequencer #(.D(D), .SD(SD), .DONE_ADDR(DONE_ADDR)) dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .reljump_en (reljump_en),
        .offset     (offset),
        .absjump_en (absjump_en),
        .target     (target),
        .call_en    (call_en),
        .ret_en     (ret_en),
        .halt_req   (halt_req),
        .prog_ctr   (prog_ctr),
        .depth      (depth),
        .done       (done),
        .stack_ovf  (stack_ovf),
        .stack_unf  (stack_unf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, "_pc"},    32'(prog_ctr),  mPc);
        checkOutput({tag, "_depth"}, 32'(depth),     mStack.size());
        checkOutput({tag, "_done"},  32'(done),      32'(mDone));
        checkOutput({tag, "_ovf"},   32'(stack_ovf), 32'(mOvf));
        checkOutput({tag, "_unf"},   32'(stack_unf), 32'(mUnf));
    endtask

    // One clock of the reference behaviour, evaluated on the inputs seen at the edge.
    function automatic void modelStep();
        bit finishNow;
        int off;
        if (mDone) return;
        finishNow = halt_req || (mPc >= DONE_ADDR);
        if (stall) begin
        end else if (ret_en) begin
            if (mStack.size() > 0) mPc = mStack.pop_back();
            else begin mUnf = 1; mPc = (mPc + 1) % MOD; end
        end else if (call_en) begin
            if (mStack.size() < SD) begin
                mStack.push_back((mPc + 1) % MOD);
                mPc = int'(target);
            end else begin
                mOvf = 1;
                mPc  = (mPc + 1) % MOD;
            end
        end else if (absjump_en) begin
            mPc = int'(target);
        end else if (reljump_en) begin
            off = int'(offset);
            if (off >= MOD / 2) off = off - MOD;
            mPc = ((mPc + off) % MOD + MOD) % MOD;
        end else begin
            mPc = (mPc + 1) % MOD;
        end
        if (finishNow) mDone = 1;
    endfunction

    task automatic applyStimulus(input bit st, input bit rj, input int off, input bit aj,
                                 input int tgt, input bit cl, input bit rt, input bit hl);
        stall      = st;
        reljump_en = rj;
        offset     = off[D-1:0];
        absjump_en = aj;
        target     = tgt[D-1:0];
        call_en    = cl;
        ret_en     = rt;
        halt_req   = hl;
        @(posedge clk);
        modelStep();
        #1;
        checkAll("step");
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic doReset();
        #2;
        reset = 1'b0;
        #1;
        mPc = 0;
        mStack.delete();
        mDone = 0;
        mOvf  = 0;
        mUnf  = 0;
        checkAll("reset");
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic runTo(input int n);
        for (int i = 0; i < 5000 && mPc != n; i++) idle();
        checkOutput("runTo", 32'(prog_ctr), n);
    endtask

    initial begin
        bit st, rj, aj, cl, rt, hl;
        errors = 0;
        checks = 0;
        reset  = 1'b0;
        stall = 0; reljump_en = 0; absjump_en = 0; call_en = 0; ret_en = 0; halt_req = 0;
        offset = '0; target = '0;
        #12;
        doReset();
        checkOutput("rst_pc_const", 32'(prog_ctr), 0);

        for (int i = 1; i <= 5; i++) begin
            idle();
            checkOutput("free_run_pc", 32'(prog_ctr), i);
        end

        runTo(10);
        applyStimulus(0, 0, 0, 0, 100, 1, 0, 0);
        checkOutput("nest_call1_pc", 32'(prog_ctr), 100);
        applyStimulus(0, 0, 0, 0, 200, 1, 0, 0);
        checkOutput("nest_call2_pc", 32'(prog_ctr), 200);
        checkOutput("nest_call2_depth", 32'(depth), 2);
        idle();
        idle();
        checkOutput("nest_inc_pc", 32'(prog_ctr), 202);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("nest_ret1_pc", 32'(prog_ctr), 101);
        checkOutput("nest_ret1_depth", 32'(depth), 1);
        applyStimulus(0, 0, 0, 0, 0, 1, 1, 0);
        checkOutput("nest_ret2_pc", 32'(prog_ctr), 11);
        checkOutput("nest_ret2_depth", 32'(depth), 0);
        checkOutput("callret_ovf", 32'(stack_ovf), 0);

        doReset();
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 0, 0, 50, 1, 0, 0);
        checkOutput("ovf_depth", 32'(depth), 4);
        checkOutput("ovf_flag", 32'(stack_ovf), 1);
        checkOutput("ovf_pc", 32'(prog_ctr), 51);

        doReset();
        runTo(7);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);
        checkOutput("unf_pc", 32'(prog_ctr), 8);
        for (int i = 0; i < 20; i++) idle();
        checkOutput("unf_sticky", 32'(stack_unf), 1);

        doReset();
        runTo(5);
        applyStimulus(0, 1, 'hFFD, 0, 0, 0, 0, 0);
        checkOutput("rel_back_pc", 32'(prog_ctr), 2);
        applyStimulus(0, 0, 0, 1, 4090, 0, 0, 0);
        applyStimulus(0, 1, 10, 0, 0, 0, 0, 0);
        checkOutput("rel_wrap_pc", 32'(prog_ctr), 4);

        doReset();
        applyStimulus(0, 0, 0, 1, 709, 0, 0, 0);
        runTo(711);
        checkOutput("done_before", 32'(done), 0);
        idle();
        checkOutput("done_set", 32'(done), 1);
        checkOutput("done_pc", 32'(prog_ctr), 712);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 30, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1);
        checkOutput("done_hold_pc", 32'(prog_ctr), 712);
        checkOutput("done_hold_depth", 32'(depth), 0);

        doReset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) doReset();
            st = ($urandom_range(0, 7) == 0);
            rt = ($urandom_range(0, 5) == 0);
            cl = ($urandom_range(0, 4) == 0);
            aj = ($urandom_range(0, 7) == 0);
            rj = ($urandom_range(0, 5) == 0);
            hl = ($urandom_range(0, 63) == 0);
            applyStimulus(st, rj, int'($urandom_range(0, MOD - 1)), aj,
                          int'($urandom_range(0, 760)), cl, rt, hl);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
